// File: rtl/ysyx_201979054_burst_ctrl_if.sv
// rtl/ysyx_201979054_burst_ctrl_if.sv - descriptor, beat and status signals of the AXI4 burst tracker
interface ysyx_201979054_burst_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic                  i_start;
    logic                  o_start_ready;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [LEN_WIDTH-1:0]  i_len;
    logic [2:0]            i_size;
    logic [1:0]            i_burst;
    logic                  i_beat;
    logic                  i_abort;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [LEN_WIDTH-1:0]  o_beat_idx;
    logic                  o_last;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;

    // The master FSM issues descriptors and reports completed beats.
    modport master (
        output i_start, i_addr, i_len, i_size, i_burst, i_beat, i_abort,
        input  o_start_ready, o_addr, o_beat_idx, o_last, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_addr, i_len, i_size, i_burst, i_beat, i_abort,
        output o_start_ready, o_addr, o_beat_idx, o_last, o_busy, o_done, o_err
    );
endinterface

// File: rtl/ysyx_201979054_burst_ctrl.sv
// rtl/ysyx_201979054_burst_ctrl.sv - AXI4 full-burst tracker: per-beat address, index, last and done
module ysyx_201979054_burst_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int MAX_SIZE   = 3
) (
    input  logic                          clk,
    input  logic                          arst,
    ysyx_201979054_burst_ctrl_if.slave    bus
);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [2:0] MAX_SIZE_L  = 3'(MAX_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;

    logic                  last;
    logic                  desc_legal;
    logic                  wrap_len_ok;
    logic [ADDR_WIDTH-1:0] in_step;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] next_addr;

    // Descriptor legality is judged on the live inputs in the accept cycle.
    assign in_step     = ONE << bus.i_size;
    assign wrap_len_ok = (bus.i_len == LEN_WIDTH'(1)) || (bus.i_len == LEN_WIDTH'(3)) ||
                         (bus.i_len == LEN_WIDTH'(7)) || (bus.i_len == LEN_WIDTH'(15));

    always_comb begin
        desc_legal = 1'b1;
        if (bus.i_burst == BURST_RSVD) begin
            desc_legal = 1'b0;
        end
        if (bus.i_size > MAX_SIZE_L) begin
            desc_legal = 1'b0;
        end
        if (bus.i_burst == BURST_WRAP) begin
            if (!wrap_len_ok || ((bus.i_addr & (in_step - ONE)) != '0)) begin
                desc_legal = 1'b0;
            end
        end
    end

    // WRAP keeps the upper address bits and lets the low bits roll inside the burst window.
    assign step      = ONE << size_q;
    assign wrap_mask = ((ADDR_WIDTH'(len_q) + ONE) << size_q) - ONE;
    assign incr_addr = addr_q + step;

    always_comb begin
        next_addr = addr_q;
        case (burst_q)
            BURST_FIXED: next_addr = addr_q;
            BURST_INCR:  next_addr = incr_addr;
            BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = addr_q;
        endcase
    end

    assign last = (state_q == ST_BURST) && (idx_q == len_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    len_d   = bus.i_len;
                    size_d  = bus.i_size;
                    burst_d = bus.i_burst;
                    if (desc_legal) begin
                        state_d = ST_BURST;
                        addr_d  = bus.i_addr;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_BURST: begin
                // Abort wins over a beat reported in the same cycle.
                if (bus.i_abort) begin
                    state_d = ST_IDLE;
                end else if (bus.i_beat) begin
                    if (last) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d  = idx_q + LEN_WIDTH'(1);
                        addr_d = next_addr;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
        end
    end

    assign bus.o_start_ready = (state_q == ST_IDLE);
    assign bus.o_busy        = (state_q == ST_BURST);
    assign bus.o_done        = (state_q == ST_DONE);
    assign bus.o_err         = (state_q == ST_ERR);
    assign bus.o_last        = last;
    assign bus.o_addr        = addr_q;
    assign bus.o_beat_idx    = idx_q;

endmodule
